// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    DRAIN
  } uart_arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set bit of req searching upward
// from rr_ptr+1, wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// streams; a grant lasts one burst, then waits for the line to go idle.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = UART_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_vld,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_rdy,
  output logic                        tx_data_vld,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_tready,
  input  logic                        tx_busy,
  output logic                        grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  uart_arb_state_e state_q, state_d;
  logic             grant_vld_q, grant_vld_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  logic                             pick_found;
  logic [IDX_W-1:0]                 pick_idx;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data_a;
  logic                             own_vld, own_last;
  logic [DATA_W-1:0]                own_data;

  assign req_data_a = req_data;
  assign own_vld    = req_vld[grant_id_q];
  assign own_last   = req_last[grant_id_q];
  assign own_data   = req_data_a[grant_id_q];

  uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req_vld),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_vld_d = grant_vld_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    tx_data_vld = 1'b0;
    tx_data     = '0;
    req_rdy     = '0;
    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        if (pick_found) begin
          grant_id_d  = pick_idx;
          grant_vld_d = 1'b1;
          state_d     = GRANTED;
        end
      end
      GRANTED: begin
        // Owner's stream passes straight through; a dropped valid just stalls.
        tx_data_vld         = own_vld;
        tx_data             = own_data;
        req_rdy[grant_id_q] = tx_tready && own_vld;
        if (own_vld && tx_tready) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (own_last || byte_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            rr_ptr_d = grant_id_q;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Busy rises a cycle after the last accept, so both flags are needed.
        if (!tx_busy && tx_tready) begin
          grant_vld_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_vld_q <= 1'b0;
      grant_id_q  <= '0;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_vld_q <= grant_vld_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign grant_vld = grant_vld_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-built burst
// scenarios and randomized streams against a burst-level reference model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_vld, req_last, req_rdy;
  logic [NR*DW-1:0]  req_data;
  logic              tx_data_vld, tx_tready, tx_busy, grant_vld;
  logic [DW-1:0]     tx_data;
  logic [1:0]        grant_id;

  logic use_model, man_tready, man_busy;
  int   busy_cnt;
  int   checks = 0;
  int   errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_rdy     (req_rdy),
    .tx_data_vld (tx_data_vld),
    .tx_data     (tx_data),
    .tx_tready   (tx_tready),
    .tx_busy     (tx_busy),
    .grant_vld   (grant_vld),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  // UART line model: accept when idle, then stay busy for 1..4 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_data_vld && tx_tready) busy_cnt <= 1 + int'($urandom_range(3));
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy   = use_model ? (busy_cnt != 0) : man_busy;
  assign tx_tready = use_model ? (busy_cnt == 0) : man_tready;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [31:0] data;
    logic        tready;
    logic        busy;
    logic        txv;
    logic [7:0]  txd;
    logic [3:0]  rdy;
    logic        gv;
    logic [1:0]  gid;
  } vec_t;
  vec_t tbl[21];

  // Reference state: per-requester byte streams {last, data} and burst bookkeeping.
  logic [8:0]    q[NR][$];
  logic [NR-1:0] en;
  int            acc_cnt[NR];
  int            grant_q[$];
  int            blen_q[$];
  logic          prev_gv, prev_busy, prev_tready, ended;
  logic [1:0]    prev_gid;
  logic [NR-1:0] prev_vld;
  int            last_owner, cnt;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_exp(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_burst(input int i, input int len);
    for (int j = 0; j < len; j++) q[i].push_back({(j == len - 1), 8'($urandom)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = '0; req_vld = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < NR; i++) begin q[i].delete(); acc_cnt[i] = 0; end
    grant_q.delete(); blen_q.delete();
    prev_gv = 1'b0; prev_gid = 2'd0; prev_vld = '0; prev_busy = 1'b0; prev_tready = 1'b1;
    last_owner = NR - 1; cnt = 0; ended = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of stimulus plus burst-level checks, sampled mid-cycle.
  task automatic cycle();
    logic [NR-1:0]    v, l, oh;
    logic [NR*DW-1:0] d;
    logic [8:0]       h;
    logic             xfer;
    int               e;
    @(negedge clk);
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NR; i++) begin
      d[i*DW +: DW] = DW'($urandom);
      l[i] = 1'($urandom);
      if (en[i] && q[i].size() > 0) begin
        h = q[i][0];
        v[i] = 1'b1; d[i*DW +: DW] = h[7:0]; l[i] = h[8];
      end
    end
    req_vld = v; req_data = d; req_last = l;
    #1;
    if (grant_vld && !prev_gv) begin
      e = rr_exp(prev_vld, last_owner);
      chk(int'(grant_id) == e, "rr_order", 32'(grant_id), 32'(e));
      last_owner = int'(grant_id); cnt = 0; ended = 1'b0;
      grant_q.push_back(int'(grant_id));
    end
    if (!grant_vld && prev_gv) begin
      chk(ended, "burst_end", 32'(cnt), 32'(MB));
      chk(!prev_busy && prev_tready, "drain_exit", {30'd0, prev_busy, prev_tready}, 32'd1);
      blen_q.push_back(cnt);
    end
    if (grant_vld && prev_gv) chk(grant_id == prev_gid, "gid_stable", 32'(grant_id), 32'(prev_gid));
    xfer = tx_data_vld && tx_tready;
    oh = '0;
    if (xfer) oh[grant_id] = 1'b1;
    chk(req_rdy == oh, "req_rdy", 32'(req_rdy), 32'(oh));
    if (!grant_vld)
      chk(!tx_data_vld && tx_data == '0, "idle_tx", {23'd0, tx_data_vld, tx_data}, 32'd0);
    else if (ended)
      chk(!tx_data_vld, "drain_txv", 32'(tx_data_vld), 32'd0);
    else begin
      chk(tx_data_vld == v[grant_id], "pass_vld", 32'(tx_data_vld), 32'(v[grant_id]));
      if (tx_data_vld && q[grant_id].size() > 0) begin
        h = q[grant_id][0];
        chk(tx_data == h[7:0], "pass_data", 32'(tx_data), 32'(h[7:0]));
      end
    end
    if (xfer && q[grant_id].size() > 0) begin
      h = q[grant_id].pop_front();
      cnt++; acc_cnt[grant_id]++;
      chk(cnt <= MB, "burst_len", 32'(cnt), 32'(MB));
      if (h[8] || cnt == MB) ended = 1'b1;
    end
    prev_gv = grant_vld; prev_gid = grant_id; prev_vld = v;
    prev_busy = tx_busy; prev_tready = tx_tready;
  endtask

  task automatic drain_all(input int bound);
    int n;
    bit done;
    en = '1; n = 0; done = 1'b0;
    while (!done && n < bound) begin
      cycle(); n++;
      done = !grant_vld && all_empty();
    end
    chk(done, "drain_timeout", 32'(n), 32'(bound));
  endtask

  initial begin
    int n;
    rst = 1'b1; use_model = 1'b0; man_tready = 1'b1; man_busy = 1'b0;
    req_vld = '0; req_last = '0; req_data = '0; en = '0;

    // rst vld last data tready busy | txv txd rdy gv gid
    tbl = '{
      '{1'b1, 4'h0, 4'h0, 32'h0,    1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0},
      '{1'b0, 4'h0, 4'h0, 32'h0,    1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0},
      '{1'b0, 4'h1, 4'h0, 32'hA5,   1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0},
      '{1'b0, 4'h1, 4'h0, 32'hA5,   1'b1, 1'b0, 1'b1, 8'hA5, 4'h1, 1'b1, 2'd0},
      '{1'b0, 4'h1, 4'h0, 32'h3C,   1'b0, 1'b1, 1'b1, 8'h3C, 4'h0, 1'b1, 2'd0},
      '{1'b0, 4'h1, 4'h0, 32'h3C,   1'b1, 1'b0, 1'b1, 8'h3C, 4'h1, 1'b1, 2'd0},
      '{1'b0, 4'h1, 4'h1, 32'h81,   1'b0, 1'b1, 1'b1, 8'h81, 4'h0, 1'b1, 2'd0},
      '{1'b0, 4'h1, 4'h1, 32'h81,   1'b1, 1'b0, 1'b1, 8'h81, 4'h1, 1'b1, 2'd0},
      '{1'b0, 4'h0, 4'h0, 32'h0,    1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0},
      '{1'b0, 4'h0, 4'h0, 32'h0,    1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0},
      '{1'b0, 4'h0, 4'h0, 32'h0,    1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0},
      '{1'b0, 4'h2, 4'h0, 32'h2200, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0},
      '{1'b0, 4'h1, 4'h0, 32'h2211, 1'b1, 1'b0, 1'b0, 8'h22, 4'h0, 1'b1, 2'd1},
      '{1'b0, 4'h1, 4'h0, 32'h2211, 1'b1, 1'b0, 1'b0, 8'h22, 4'h0, 1'b1, 2'd1},
      '{1'b0, 4'h2, 4'h0, 32'h2211, 1'b1, 1'b0, 1'b1, 8'h22, 4'h2, 1'b1, 2'd1},
      '{1'b1, 4'h2, 4'h0, 32'h2211, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0},
      '{1'b0, 4'hF, 4'hF, 32'h2211, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0},
      '{1'b0, 4'hF, 4'hF, 32'h2211, 1'b1, 1'b0, 1'b1, 8'h11, 4'h1, 1'b1, 2'd0},
      '{1'b0, 4'hF, 4'hF, 32'h2211, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0},
      '{1'b0, 4'h0, 4'h0, 32'h0,    1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0},
      '{1'b0, 4'h0, 4'h0, 32'h0,    1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0}
    };

    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      rst = tbl[k].rst; req_vld = tbl[k].vld; req_last = tbl[k].last;
      req_data = tbl[k].data; man_tready = tbl[k].tready; man_busy = tbl[k].busy;
      #1;
      chk(tx_data_vld == tbl[k].txv, $sformatf("vec%0d_txv", k), 32'(tx_data_vld), 32'(tbl[k].txv));
      chk(req_rdy == tbl[k].rdy, $sformatf("vec%0d_rdy", k), 32'(req_rdy), 32'(tbl[k].rdy));
      chk(grant_vld == tbl[k].gv, $sformatf("vec%0d_gv", k), 32'(grant_vld), 32'(tbl[k].gv));
      chk(grant_id == tbl[k].gid, $sformatf("vec%0d_gid", k), 32'(grant_id), 32'(tbl[k].gid));
      if (tbl[k].txv || !tbl[k].gv)
        chk(tx_data == tbl[k].txd, $sformatf("vec%0d_txd", k), 32'(tx_data), 32'(tbl[k].txd));
    end

    use_model = 1'b1;

    // Quiet line after reset.
    do_reset();
    repeat (10) cycle();
    chk(grant_q.size() == 0, "idle_grants", 32'(grant_q.size()), 32'd0);

    // All four requesting single-byte bursts: strict rotation.
    do_reset();
    for (int i = 0; i < NR; i++) begin push_burst(i, 1); push_burst(i, 1); end
    drain_all(300);
    chk(grant_q.size() == 8, "rr_count", 32'(grant_q.size()), 32'd8);
    for (int k = 0; k < grant_q.size() && k < 8; k++)
      chk(grant_q[k] == k % NR, $sformatf("rr_seq%0d", k), 32'(grant_q[k]), 32'(k % NR));

    // Long stream from requester 2 gets cut at MAX_BURST, requester 3 slips in.
    do_reset();
    push_burst(2, 20); push_burst(3, 2);
    drain_all(500);
    chk(grant_q.size() == 3, "mb_grants", 32'(grant_q.size()), 32'd3);
    if (grant_q.size() == 3 && blen_q.size() == 3) begin
      chk(grant_q[0] == 2 && blen_q[0] == MB, "mb_first", 32'(blen_q[0]), 32'(MB));
      chk(grant_q[1] == 3 && blen_q[1] == 2, "mb_second", 32'(grant_q[1]), 32'd3);
      chk(grant_q[2] == 2 && blen_q[2] == 4, "mb_resume", 32'(blen_q[2]), 32'd4);
    end

    // Owner goes quiet mid-burst: grant held, no re-arbitration.
    do_reset();
    push_burst(1, 4); push_burst(0, 1);
    en = 4'b0010; n = 0;
    while (acc_cnt[1] < 2 && n < 100) begin cycle(); n++; end
    chk(acc_cnt[1] == 2, "drop_setup", 32'(acc_cnt[1]), 32'd2);
    en = 4'b0001;
    repeat (5) begin
      cycle();
      chk({grant_vld, grant_id, tx_data_vld} == 4'hA, "hold_grant",
          32'({grant_vld, grant_id, tx_data_vld}), 32'hA);
    end
    drain_all(200);
    chk(grant_q.size() == 2 && grant_q[0] == 1 && grant_q[1] == 0, "drop_order",
        32'(grant_q.size()), 32'd2);
    if (blen_q.size() == 2) chk(blen_q[0] == 4 && blen_q[1] == 1, "drop_len", 32'(blen_q[0]), 32'd4);

    // Randomized streams with random valid gaps; requester 3 runs long bursts.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        en[i] = ($urandom_range(3) != 0);
        if (q[i].size() == 0 && c < 2800)
          push_burst(i, (i == 3) ? 1 + int'($urandom_range(39)) : 1 + int'($urandom_range(9)));
      end
      cycle();
    end
    drain_all(3000);
    for (int i = 0; i < NR; i++)
      chk(acc_cnt[i] > 0, $sformatf("served%0d", i), 32'(acc_cnt[i]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters.
- A requester holds its grant for a whole burst, which ends on req_last or after MAX_BURST bytes.
- The arbiter then waits for the line to go idle and rotates priority.
- Sits directly upstream of the UART TX core and drives its data valid/data inputs.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, byte width, must match UART TX data width
MAX_BURST, 16, max bytes per grant before forced rotation (>=1)

Ports:
clk  input  1  clock
rst  input  1  async active-high reset
req_vld  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*DATA_W  per-requester byte, requester i at [i*DATA_W +: DATA_W]
req_last  input  NUM_REQ  marks final byte of burst, qualified by req_vld
req_rdy  output  NUM_REQ  per-requester byte accepted this cycle
tx_data_vld  output  1  to UART TX t_data_port_vld
tx_data  output  DATA_W  to UART TX t_data_port
tx_tready  input  1  UART TX ready (high only when UART idle)
tx_busy  input  1  UART TX busy
grant_vld  output  1  a requester currently owns the UART
grant_id  output  $clog2(NUM_REQ)  owning requester index

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, grant_vld=0, grant_id=0, tx_data_vld=0, tx_data=0, req_rdy=0, byte_cnt=0, rr_ptr=NUM_REQ-1 (so requester 0 has first priority).

FSM states: IDLE, GRANTED, DRAIN.

IDLE:
- If any req_vld, select the first requester with req_vld=1 searching from rr_ptr+1 upward, with wrap modulo NUM_REQ.
- Register grant_id, set grant_vld=1, clear byte_cnt, go to GRANTED.
- Arbitration latency is 1 cycle: req_vld high in cycle N means tx_data_vld is earliest high in N+1.
- No req_vld: stay in IDLE, all outputs at reset values except rr_ptr and grant_id, which hold.

GRANTED:
- tx_data_vld = req_vld[grant_id] and tx_data = req_data[grant_id], combinational pass-through.
- req_rdy[grant_id] = tx_tready && req_vld[grant_id]. All other req_rdy bits are 0.
- A transfer occurs when tx_data_vld && tx_tready. Each transfer increments byte_cnt.
- If the transfer has req_last[grant_id]=1 or byte_cnt==MAX_BURST-1: set rr_ptr<=grant_id and go to DRAIN.
- If the owner deasserts req_vld mid-burst, the grant is held indefinitely with tx_data_vld=0. There is no timeout.

DRAIN:
- tx_data_vld=0, req_rdy=0, grant_vld stays 1.
- The UART raises busy one cycle after accept and ignores the handshake while busy.
- Leave DRAIN only when tx_busy=0 && tx_tready=1. Then set grant_vld<=0 and go to IDLE.
- Earliest exit is 2 cycles after the final transfer.

Rules and boundary conditions:
- grant_id is stable for the whole GRANTED+DRAIN interval.
- grant_id never changes while tx_busy=1.
- byte_cnt width is $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1 in GRANTED.
- MAX_BURST=1: every byte forces rotation.
- Simultaneous requests: round-robin order only, with no fixed priority after the first grant.
- A single active requester regains the grant on every round. Its bursts are separated by DRAIN plus 1 IDLE cycle.
- Reset mid-operation: state and outputs return to reset values immediately. The in-flight UART frame is handled by the UART's own reset on the same rst.
- At most one req_rdy bit is high in any cycle.
- tx_data_vld is never high outside GRANTED.

Decomposition:
- Package uart_pkg: state enum uart_arb_state_e {IDLE, GRANTED, DRAIN}, UART_DATA_W=8 constant.
- One sub-module, uart_rr_pick: combinational round-robin selector.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, idx.
  - Verified standalone.

Test Plan:
- Reset release, no requests -> grant_vld=0, tx_data_vld=0, req_rdy=0 indefinitely.
- req_vld=4'b0001, 3-byte burst 0xA5,0x3C,0x81 with last on 0x81, UART model accepting -> grant_id=0 one cycle after req_vld; bytes appear on tx_data in order; DRAIN until tx_busy falls; grant_vld drops.
- req_vld=4'b1111 continuous, each burst 1 byte with last=1 -> grant order 0,1,2,3,0; no requester granted twice before all others are served.
- Requester 2 streams 20 bytes with no last, MAX_BURST=16, requester 3 also valid -> 16 bytes transferred, forced rotation, then grant_id=3; requester 2 resumes after requester 3's burst.
- Owner drops req_vld for 5 cycles mid-burst -> grant held, tx_data_vld=0 for those cycles, burst resumes without re-arbitration.
- rst asserted in GRANTED between bytes -> all outputs return to reset values in the same cycle; first grant after release goes to requester 0.
